if_fetch_queue: RTL and testbench

- Instruction-fetch front end feeding the decode stage of the 5-stage core.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in an in-order queue and presents instruction, PC and pre-split opcode/funct3/funct7 fields to the decode-stage control logic.
- Handles decode stalls and redirects from taken branches/jumps, discarding stale in-flight responses.

---
 rtl/if_fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues word fetches over req/gnt/rvalid,
// buffers in-order responses with their PCs and presents the head entry
// (with pre-split opcode/funct3/funct7) to the decode stage.
// Optional build macro: IFQ_BYPASS_EN -- when defined, a live response that
// arrives while the queue is empty drives the D outputs in the same cycle.
//
// Handshakes:
//   imem: a request transfers on a cycle with imem_req && imem_gnt; once raised,
//         imem_req/imem_addr hold until granted unless a redirect withdraws them.
//         Responses (imem_rvalid) return one per cycle, in request order.
//   decode: validD is the valid, !stallD is the ready; the head entry is
//         consumed on a clock edge where validD && !stallD.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stallD,
  input  logic            redirectE,
  input  logic [XLEN-1:0] pcTargetE,
  output logic            validD,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcPlus4D,
  output logic [6:0]      opcodeD,
  output logic [2:0]      funct3D,
  output logic [6:0]      funct7D
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]   tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] tag_mem_q   [DEPTH];

  logic            grant, live_rsp, stale_rsp, push_en, pop_en;
  logic [XLEN-1:0] rsp_pc, head_instr, head_pc;

  // Request credit, response classification and head selection
  always_comb begin
    imem_req  = !rst && !redirectE &&
                ((SW'(count_q) + SW'(out_q)) < SW'(DEPTH));
    imem_addr = fetch_pc_q;
    grant     = imem_req && imem_gnt;
    live_rsp  = imem_rvalid && (drop_q == '0);
    stale_rsp = imem_rvalid && (drop_q != '0);
    rsp_pc    = tag_mem_q[tag_head_q];
`ifdef IFQ_BYPASS_EN
    // An empty queue lets a live response flow straight to decode; it is only
    // written into storage if decode stalls this cycle.
    validD     = (count_q != '0) ||
                 (live_rsp && !redirectE && !rst);
    head_instr = (count_q != '0) ? instr_mem_q[head_q] : imem_rdata;
    head_pc    = (count_q != '0) ? pc_mem_q[head_q] : rsp_pc;
    pop_en     = (count_q != '0) && !stallD && !redirectE;
    push_en    = live_rsp && !redirectE && ((count_q != '0) || stallD);
`else
    validD     = (count_q != '0);
    head_instr = instr_mem_q[head_q];
    head_pc    = pc_mem_q[head_q];
    pop_en     = validD && !stallD && !redirectE;
    push_en    = live_rsp && !redirectE;
`endif
    instrD   = validD ? head_instr : NOP;
    pcD      = validD ? head_pc : '0;
    pcPlus4D = pcD + XLEN'(4);
    opcodeD  = instrD[6:0];
    funct3D  = instrD[14:12];
    funct7D  = instrD[31:25];
  end

  // Next-state: a redirect flushes everything and turns every in-flight
  // request (including one returning right now) into a response to discard
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_head_d = tag_head_q;
    tag_tail_d = tag_tail_q;
    if (redirectE) begin
      fetch_pc_d = pcTargetE & ~XLEN'(3);
      count_d    = '0;
      out_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      tag_head_d = '0;
      tag_tail_d = '0;
      drop_d     = drop_q + out_q + CW'(grant) - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        tag_tail_d = tag_tail_q + AW'(1);
      end
      if (live_rsp)  tag_head_d = tag_head_q + AW'(1);
      if (stale_rsp) drop_d = drop_q - CW'(1);
      if (push_en)   tail_d = tail_q + AW'(1);
      if (pop_en)    head_d = head_q + AW'(1);
      out_d   = out_q + CW'(grant) - CW'(live_rsp);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_head_q <= '0;
      tag_tail_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_head_q <= tag_head_d;
      tag_tail_q <= tag_tail_d;
    end
  end

  // Entry storage and PC tags of in-flight requests (no reset needed)
  always_ff @(posedge clk) begin
    if (push_en) begin
      instr_mem_q[tail_q] <= imem_rdata;
      pc_mem_q[tail_q]    <= rsp_pc;
    end
    if (grant) tag_mem_q[tag_tail_q] <= fetch_pc_q;
  end

  // The credit rule keeps a live response from ever meeting a full queue
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    live_rsp |-> (count_q != CW'(DEPTH)));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    live_rsp |-> (out_q != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            stallD;
  logic            redirectE;
  logic [XLEN-1:0] pcTargetE;
  logic            validD;
  logic [XLEN-1:0] instrD, pcD, pcPlus4D;
  logic [6:0]      opcodeD;
  logic [2:0]      funct3D;
  logic [6:0]      funct7D;

  int checks = 0;
  int errors = 0;

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stallD(stallD), .redirectE(redirectE), .pcTargetE(pcTargetE),
    .validD(validD), .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D),
    .opcodeD(opcodeD), .funct3D(funct3D), .funct7D(funct7D)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h00A58533 ^ (a << 20) ^ (a << 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] pend_q[$];
  bit          rsp_hold = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_gnt) pend_q.push_back(imem_addr);
    end
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        pend_q.delete();
        imem_rvalid = 1'b0;
      end else if (!rsp_hold && pend_q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // exp_q/pc_q: delivered-but-unconsumed instructions; tag_q: PCs requested and
  // not yet returned; m_drop: responses still owed from before a redirect.
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] pc_q[$];
  logic [XLEN-1:0] tag_q[$];
  int              m_drop = 0;
  logic [XLEN-1:0] m_pc = '0;

  initial begin
    logic [XLEN-1:0] tmp;
    bit m_req;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete(); pc_q.delete(); tag_q.delete();
        m_drop = 0;
        m_pc   = 32'h0;
      end else begin
        m_req = !redirectE && ((exp_q.size() + tag_q.size()) < DEPTH);
        if (redirectE) begin
          // every request still in flight becomes stale; one may return now
          m_drop = m_drop + tag_q.size() - (imem_rvalid ? 1 : 0);
          exp_q.delete(); pc_q.delete(); tag_q.delete();
          m_pc = pcTargetE & ~32'h3;
        end else begin
          if (exp_q.size() > 0 && !stallD) begin
            tmp = exp_q.pop_front();
            tmp = pc_q.pop_front();
          end
          if (imem_rvalid) begin
            if (m_drop > 0) m_drop--;
            else if (tag_q.size() > 0) begin
              exp_q.push_back(imem_rdata);
              pc_q.push_back(tag_q.pop_front());
            end
          end
          if (m_req && imem_gnt) begin
            tag_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit          e_req, e_valid;
    logic [31:0] e_instr, e_pc;
    forever begin
      @(negedge clk);
      e_req   = !rst && !redirectE && ((exp_q.size() + tag_q.size()) < DEPTH);
      e_valid = exp_q.size() > 0;
      e_instr = e_valid ? exp_q[0] : NOP;
      e_pc    = e_valid ? pc_q[0] : 32'h0;
      check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("imem_addr", imem_addr, m_pc);
      check("validD", {31'b0, validD}, {31'b0, e_valid});
      check("instrD", instrD, e_instr);
      check("pcD", pcD, e_pc);
      check("pcPlus4D", pcPlus4D, e_pc + 32'd4);
      check("opcodeD", {25'b0, opcodeD}, {25'b0, e_instr[6:0]});
      check("funct3D", {29'b0, funct3D}, {29'b0, e_instr[14:12]});
      check("funct7D", {25'b0, funct7D}, {25'b0, e_instr[31:25]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (validD === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for validD expected pcD=%h", name, exp_pc);
    end else begin
      check(name, pcD, exp_pc);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; imem_gnt = 1'b1; stallD = 1'b0; redirectE = 1'b0; pcTargetE = '0;

    // reset values, then streaming from RESET_PC
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, validD}, 32'd0);
    check("rst_instr", instrD, 32'h0000_0013);
    check("rst_pc", pcD, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("a_req0", {31'b0, imem_req}, 32'd1);
    check("a_addr0", imem_addr, 32'h0);
    next_cycle();
    @(negedge clk); #1;
    check("a_addr1", imem_addr, 32'h4);
    check("a_valid_early", {31'b0, validD}, 32'd0);
    next_cycle();
    @(negedge clk); #1;
    check("a_addr2", imem_addr, 32'h8);
    check("a_valid", {31'b0, validD}, 32'd1);
    check("a_pcD", pcD, 32'h0);
    check("a_pc4", pcPlus4D, 32'h4);
    check("a_instr", instrD, 32'h00A58533);
    check("a_opcode", {25'b0, opcodeD}, 32'h33);
    check("a_funct3", {29'b0, funct3D}, 32'h0);
    check("a_funct7", {25'b0, funct7D}, 32'h0);
    repeat (4) next_cycle();

    // stall + redirect together, then credit limit under stall
    redirectE = 1'b1; pcTargetE = 32'h40; stallD = 1'b1;
    next_cycle();
    redirectE = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_gnt) n++;
      next_cycle();
    end
    check("b_grants", n, 32'd4);
    @(negedge clk); #1;
    check("b_req_off", {31'b0, imem_req}, 32'd0);
    next_cycle();
    stallD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("b_valid", {31'b0, validD}, 32'd1);
      check("b_pc_seq", pcD, 32'h40 + 32'(4 * i));
      next_cycle();
    end

    // three outstanding, redirect to 0x100, stale responses discarded
    imem_gnt = 1'b0;
    repeat (6) next_cycle();
    imem_gnt = 1'b1; rsp_hold = 1'b1;
    repeat (3) next_cycle();
    imem_gnt = 1'b0; redirectE = 1'b1; pcTargetE = 32'h100;
    @(negedge clk); #1;
    check("d_redir_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    redirectE = 1'b0; imem_gnt = 1'b1; rsp_hold = 1'b0;
    @(negedge clk); #1;
    check("d_req", {31'b0, imem_req}, 32'd1);
    check("d_addr", imem_addr, 32'h100);
    check("d_valid_low", {31'b0, validD}, 32'd0);
    wait_valid("d_first_pc", 32'h100);

    // redirect while a response is pushed and decode stalls; unaligned target
    next_cycle();
    imem_gnt = 1'b0;
    repeat (8) next_cycle();
    imem_gnt = 1'b1; rsp_hold = 1'b1;
    repeat (3) next_cycle();
    imem_gnt = 1'b0; rsp_hold = 1'b0;
    next_cycle();
    stallD = 1'b1; redirectE = 1'b1; pcTargetE = 32'h103;
    @(negedge clk); #1;
    check("e_redir_req", {31'b0, imem_req}, 32'd0);
    check("e_valid_pre", {31'b0, validD}, 32'd1);
    next_cycle();
    redirectE = 1'b0; stallD = 1'b0; imem_gnt = 1'b1;
    @(negedge clk); #1;
    check("e_valid_low", {31'b0, validD}, 32'd0);
    check("e_nop", instrD, 32'h0000_0013);
    check("e_req", {31'b0, imem_req}, 32'd1);
    check("e_addr", imem_addr, 32'h100);
    wait_valid("e_first_pc", 32'h100);
    check("e_instr", instrD, instr_of(32'h100));

    // asynchronous reset in the middle of a burst
    next_cycle();
    repeat (5) next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("f_req", {31'b0, imem_req}, 32'd0);
    check("f_valid", {31'b0, validD}, 32'd0);
    check("f_instr", instrD, 32'h0000_0013);
    check("f_pc", pcD, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("f_req_after", {31'b0, imem_req}, 32'd1);
    check("f_addr_after", imem_addr, 32'h0);
    repeat (6) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute time bound
  initial begin
    #100000;
    $display("FAIL global_timeout reached t=%0t", $time);
    $fatal(1);
  end

endmodule
